// File: rtl/signed_seq_divider.sv
// signed_seq_divider
//   Sequential signed divider for the arithmetic test path: 8-bit signed
//   dividend Z / 4-bit signed divisor M -> 8-bit quotient Q, 4-bit remainder R.
//   Restoring division on magnitudes, one quotient bit per cycle, then a sign fix.
//   Quotient truncates toward zero; remainder takes the sign of the dividend.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request; accepted in IDLE or DONE
//   Z      in   [7:0] signed dividend, captured on accept
//   M      in   [3:0] signed divisor, captured on accept
//   Q      out  [7:0] signed quotient (registered)
//   R      out  [3:0] signed remainder (registered)
//   busy   out  high through the 8 CALC cycles and FIX
//   done   out  one-cycle pulse when Q/R/dz/ovf update
//   dz     out  divide-by-zero flag for the last result
//   ovf    out  overflow flag for the last result (-128 / -1)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// CALC  | one restoring iteration per cycle, cnt 0..7
// FIX   | apply signs / special cases, load outputs, pulse done
// DONE  | results valid; start here is accepted back-to-back

module signed_seq_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] Z,
    input  logic [3:0] M,
    output logic [7:0] Q,
    output logic [3:0] R,
    output logic       busy,
    output logic       done,
    output logic       dz,
    output logic       ovf
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t     state;
    logic [2:0] cnt;
    logic [4:0] pr;
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic       sign_q;
    logic       sign_r;
    logic       dz_cap;
    logic       ovf_cap;

    logic [7:0] z_mag;
    logic [3:0] m_mag;
    logic [5:0] pr_sh;
    logic [5:0] trial;
    logic [7:0] q_fix;
    logic [3:0] r_fix;

    // |-128| and |-8| fall out naturally as 8'h80 / 4'h8 in unsigned form.
    assign z_mag = Z[7] ? (~Z + 8'd1) : Z;
    assign m_mag = M[3] ? (~M + 4'd1) : M;

    // pr never exceeds 7, so the shifted value stays below 16 and bit 5 of
    // the trial difference is a reliable sign bit.
    assign pr_sh = {pr, dvd[7]};
    assign trial = pr_sh - {2'b00, dvs};

    // After 8 iterations dvd holds the quotient magnitude and pr the remainder.
    // Negating zero yields zero, so no explicit zero guard is needed.
    assign q_fix = sign_q ? (~dvd + 8'd1) : dvd;
    assign r_fix = sign_r ? (~pr[3:0] + 4'd1) : pr[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            pr      <= 5'd0;
            dvd     <= 8'd0;
            dvs     <= 4'd0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dz_cap  <= 1'b0;
            ovf_cap <= 1'b0;
            Q       <= 8'h00;
            R       <= 4'h0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_CALC;
                        busy    <= 1'b1;
                        cnt     <= 3'd0;
                        pr      <= 5'd0;
                        dvd     <= z_mag;
                        dvs     <= m_mag;
                        sign_q  <= Z[7] ^ M[3];
                        sign_r  <= Z[7];
                        dz_cap  <= (M == 4'h0);
                        ovf_cap <= (Z == 8'h80) && (M == 4'hF);
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    pr  <= trial[5] ? pr_sh[4:0] : trial[4:0];
                    dvd <= {dvd[6:0], ~trial[5]};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) state <= S_FIX;
                end
                S_FIX: begin
                    // Special cases override the iterated magnitudes; the
                    // latency is the same for every operand pair.
                    if (dz_cap) begin
                        Q <= 8'h00;
                        R <= 4'h0;
                    end else if (ovf_cap) begin
                        Q <= 8'h80;
                        R <= 4'h0;
                    end else begin
                        Q <= q_fix;
                        R <= r_fix;
                    end
                    dz    <= dz_cap;
                    ovf   <= ovf_cap;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_seq_divider.sv
module tb_signed_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] Z = 8'h00;
    logic [3:0] M = 4'h0;
    logic [7:0] Q;
    logic [3:0] R;
    logic       busy;
    logic       done;
    logic       dz;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    signed_seq_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .Z     (Z),
        .M     (M),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed integer division (truncating) and remainder.
    task automatic model(input logic [7:0] z, input logic [3:0] m,
                         output logic [7:0] q, output logic [3:0] r,
                         output logic edz, output logic eovf);
        int zi;
        int mi;
        zi = $signed(z);
        mi = $signed(m);
        edz = 1'b0;
        eovf = 1'b0;
        if (mi == 0) begin
            q = 8'h00; r = 4'h0; edz = 1'b1;
        end else if (zi == -128 && mi == -1) begin
            q = 8'h80; r = 4'h0; eovf = 1'b1;
        end else begin
            q = 8'(zi / mi);
            r = 4'(zi % mi);
        end
    endtask

    // Drive one request; returns #1 after the accept edge with operands scrambled.
    task automatic launch(input logic [7:0] z, input logic [3:0] m);
        start = 1'b1;
        Z = z;
        M = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        Z = 8'($urandom);
        M = 4'($urandom);
    endtask

    // Called #1 after the accept edge. Checks busy for 9 cycles, then the
    // DONE cycle. pulse_mask[k] drives a spurious start during sample k.
    task automatic check_op(input logic [7:0] z, input logic [3:0] m,
                            input logic [8:0] pulse_mask, input string tag);
        logic [7:0] eq;
        logic [3:0] er;
        logic       edz;
        logic       eovf;
        int qi, ri, mi, zi;
        model(z, m, eq, er, edz, eovf);
        for (int k = 0; k < 9; k++) begin
            chk({tag, "/busy"}, 32'(busy), 32'd1);
            chk({tag, "/early_done"}, 32'(done), 32'd0);
            if (pulse_mask[k]) begin
                start = 1'b1;
                Z = 8'($urandom);
                M = 4'($urandom);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk({tag, "/done"}, 32'(done), 32'd1);
        chk({tag, "/busy_done"}, 32'(busy), 32'd0);
        chk({tag, "/Q"}, 32'(Q), 32'(eq));
        chk({tag, "/R"}, 32'(R), 32'(er));
        chk({tag, "/dz"}, 32'(dz), 32'(edz));
        chk({tag, "/ovf"}, 32'(ovf), 32'(eovf));
        if (!edz && !eovf) begin
            qi = $signed(Q);
            ri = $signed(R);
            mi = $signed(m);
            zi = $signed(z);
            chk({tag, "/identity"}, 32'(qi * mi + ri), 32'(zi));
            chk({tag, "/rsign"}, 32'(ri == 0 || ((ri < 0) == (zi < 0))), 32'd1);
            chk({tag, "/rmag"}, 32'((ri < 0 ? -ri : ri) < (mi < 0 ? -mi : mi)), 32'd1);
        end
    endtask

    task automatic check_quiet(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk({tag, "/no_done"}, 32'(done), 32'd0);
            chk({tag, "/no_busy"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/Q"}, 32'(Q), 32'd0);
        chk({tag, "/R"}, 32'(R), 32'd0);
        chk({tag, "/busy"}, 32'(busy), 32'd0);
        chk({tag, "/done"}, 32'(done), 32'd0);
        chk({tag, "/dz"}, 32'(dz), 32'd0);
        chk({tag, "/ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        logic [11:0] pv;
        int          off;

        #12;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        launch(8'hEE, 4'hD);
        check_op(8'hEE, 4'hD, 9'd0, "neg_neg");
        launch(8'h7F, 4'h8);
        check_op(8'h7F, 4'h8, 9'd0, "max_by_m8");
        launch(8'hF9, 4'h2);
        check_op(8'hF9, 4'h2, 9'd0, "neg_by_pos");
        launch(8'h07, 4'h2);
        check_op(8'h07, 4'h2, 9'd0, "back_to_back");
        launch(8'h80, 4'hF);
        check_op(8'h80, 4'hF, 9'd0, "overflow");
        launch(8'h25, 4'h0);
        check_op(8'h25, 4'h0, 9'd0, "div_zero");
        @(posedge clk);
        #1;

        launch(8'h40, 4'h3);
        check_op(8'h40, 4'h3, 9'b000010100, "ignore_start");
        check_quiet(12, "ignore_start");

        launch(8'h11, 4'h5);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        check_quiet(15, "mid_reset");

        off = int'($urandom_range(0, 4095));
        for (int idx = 0; idx < 4096; idx++) begin
            pv = 12'(idx + off);
            launch(pv[11:4], pv[3:0]);
            check_op(pv[11:4], pv[3:0], 9'd0, "sweep");
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
